gate_bist: RTL and testbench

- Synthesizable self-test controller: the hardware counterpart of a stimulus/check bench for a small combinational gate.
- Drives every input vector exhaustively into a gate DUT, waits a settle window, and compares the DUT output with an internal golden reduction.
- Reports pass/fail, mismatch count and first failing vector.
- Sits beside `and_gate` (or any N-input reduction gate) in the top level, started by CI/board logic.

---
 rtl/gate_bist_pkg.sv | 20 ++
 rtl/gate_bist_if.sv | 41 ++++
 rtl/gate_golden.sv | 24 ++
 rtl/gate_bist.sv | 132 +++++++++++++
 tb/tb_gate_bist.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// gate_bist shared types: FSM state and golden-op encodings.
// Imported by every gate_bist file.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 2;

  localparam int SETTLE_MAX = 15;
  localparam int N_IN_MAX   = 8;

endpackage

// File: rtl/gate_bist_if.sv
// Control/status and gate-facing signals of gate_bist.
// master = the BIST controller, slave = board logic plus gate under test.
interface gate_bist_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_seen;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start,
    input  dut_y,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_seen,
    output fail_vec
  );

  modport slave (
    output start,
    output dut_y,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_seen,
    input  fail_vec
  );

endinterface

// File: rtl/gate_golden.sv
// Golden reference: N_IN-input reduction selected by OP.
// Purely combinational.
module gate_golden
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int OP   = OP_AND
) (
  input  logic [N_IN-1:0] vec,
  output logic            y
);

  if (OP == OP_AND) begin : g_and
    assign y = &vec;
  end else if (OP == OP_OR) begin : g_or
    assign y = |vec;
  end else if (OP == OP_XOR) begin : g_xor
    assign y = ^vec;
  end else begin : g_bad
    $error("gate_golden: illegal OP %0d", OP);
    assign y = 1'b0;
  end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive self-test controller for an N_IN-input reduction gate.
// Define GATE_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter int OP     = OP_AND
) (
  input logic       clk,
  input logic       rst,
  gate_bist_if.master bus
);

  if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n
    $error("gate_bist: N_IN %0d out of range", N_IN);
  end
  if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_s
    $error("gate_bist: SETTLE %0d out of range", SETTLE);
  end

  localparam logic [3:0] W_LAST =
    4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e          state;
  logic [N_IN-1:0] vcnt;
  logic [3:0]      wcnt;
  logic [N_IN-1:0] dut_in_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic            fail_seen_q;
  logic [N_IN-1:0] fail_vec_q;

  logic            gold;
  logic            miss;
  logic            last;
  logic            stop;
  logic [N_IN:0]   err_nxt;

  gate_golden #(
    .N_IN (N_IN),
    .OP   (OP)
  ) u_golden (
    .vec (dut_in_q),
    .y   (gold)
  );

  // Case inequality so an X/Z gate output is a mismatch.
  assign miss    = (bus.dut_y !== gold);
  assign last    = &vcnt;
  assign err_nxt = err_q + {{N_IN{1'b0}}, miss};

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop = last | miss;
`else
  assign stop = last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      vcnt        <= '0;
      wcnt        <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_seen_q <= 1'b0;
      fail_vec_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state       <= S_APPLY;
            vcnt        <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
          end
        end
        S_APPLY: begin
          dut_in_q <= vcnt;
          wcnt     <= '0;
          state    <= (SETTLE == 0) ? S_CHECK
                                    : S_WAIT;
        end
        S_WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (wcnt == W_LAST) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (miss) begin
            err_q <= err_nxt;
            if (!fail_seen_q) begin
              fail_seen_q <= 1'b1;
              fail_vec_q  <= dut_in_q;
            end
          end
          if (stop) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_nxt == '0);
          end else begin
            vcnt  <= vcnt + 1'b1;
            state <= S_APPLY;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_seen = fail_seen_q;
  assign bus.fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: three configurations,
// healthy and faulty gate models, reset and restart cases.
module tb_gate_bist;

  logic clk;
  logic rst;
  logic fault0;
  logic fault2;

  int checks;
  int errors;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam int L_FAULT0 = 8;
  localparam int E_FAULT0 = 2'd1;
  localparam int L_FAULT2 = 18;
`else
  localparam int L_FAULT0 = 16;
  localparam int E_FAULT0 = 2;
  localparam int L_FAULT2 = 24;
`endif

  gate_bist_if #(.N_IN(2)) b0 ();
  gate_bist_if #(.N_IN(2)) b1 ();
  gate_bist_if #(.N_IN(3)) b2 ();

  assign b0.dut_y = fault0 ? |b0.dut_in
                           : &b0.dut_in;
  assign b1.dut_y = (b1.dut_in == 2'd3) ? 1'bx
                                        : &b1.dut_in;
  assign b2.dut_y = ^b2.dut_in ^
                    (fault2 && b2.dut_in == 3'd5);

  gate_bist #(
    .N_IN(2), .SETTLE(2), .OP(0)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  gate_bist #(
    .N_IN(2), .SETTLE(0), .OP(0)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  gate_bist #(
    .N_IN(3), .SETTLE(1), .OP(2)
  ) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic done_of(input int w);
    case (w)
      0:       return b0.done;
      1:       return b1.done;
      default: return b2.done;
    endcase
  endfunction

  task automatic kick(input int w);
    case (w)
      0:       b0.start = 1'b1;
      1:       b1.start = 1'b1;
      default: b2.start = 1'b1;
    endcase
    @(posedge clk); #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
  endtask

  task automatic wait_done(input int w, output int n);
    n = 0;
    while (!done_of(w) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({b0.busy, b0.done, b0.pass,
         b0.fail_seen} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
        {b0.busy, b0.done, b0.pass, b0.fail_seen});
    end
    checks++;
    if (b0.dut_in !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut_in got %0d exp 0",
        b0.dut_in);
    end
    checks++;
    if (b0.err_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_err got %0d exp 0",
        b0.err_count);
    end
    checks++;
    if (b0.fail_vec !== 2'd0) begin
      errors++;
      $display("FAIL reset_fvec got %0d exp 0",
        b0.fail_vec);
    end
  endtask

  task automatic test_and_sweep;
    int n;
    fault0 = 1'b0;
    kick(0);
    n = 0;
    while (!b0.done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n % 4 == 1 && n < 16) begin
        checks++;
        if (b0.dut_in !== 2'((n - 1) / 4)) begin
          errors++;
          $display("FAIL seq_dut_in n=%0d got %0d exp %0d",
            n, b0.dut_in, (n - 1) / 4);
        end
      end
      if (n == 15) begin
        checks++;
        if (b0.busy !== 1'b1) begin
          errors++;
          $display("FAIL seq_busy got %b exp 1",
            b0.busy);
        end
      end
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL and_latency got %0d exp 16", n);
    end
    checks++;
    if ({b0.pass, b0.busy, b0.fail_seen} !== 3'b100) begin
      errors++;
      $display("FAIL and_flags got %b exp 100",
        {b0.pass, b0.busy, b0.fail_seen});
    end
    checks++;
    if (b0.err_count !== 3'd0 ||
        b0.fail_vec !== 2'd0) begin
      errors++;
      $display("FAIL and_result got %0d/%0d exp 0/0",
        b0.err_count, b0.fail_vec);
    end
    checks++;
    if (b0.dut_in !== 2'd3) begin
      errors++;
      $display("FAIL and_hold got %0d exp 3",
        b0.dut_in);
    end
  endtask

  task automatic test_fault;
    int n;
    fault0 = 1'b1;
    kick(0);
    wait_done(0, n);
    checks++;
    if (n != L_FAULT0) begin
      errors++;
      $display("FAIL fault_latency got %0d exp %0d",
        n, L_FAULT0);
    end
    checks++;
    if (b0.err_count !== 3'(E_FAULT0)) begin
      errors++;
      $display("FAIL fault_err got %0d exp %0d",
        b0.err_count, E_FAULT0);
    end
    checks++;
    if (b0.fail_vec !== 2'd1 ||
        {b0.fail_seen, b0.pass} !== 2'b10) begin
      errors++;
      $display("FAIL fault_vec got %0d %b exp 1 10",
        b0.fail_vec, {b0.fail_seen, b0.pass});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    fault0 = 1'b0;
    kick(0);
    n = 0;
    while (b0.dut_in !== 2'd2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL mid_reach got %0d exp 9", n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({b0.dut_in, b0.busy, b0.done, b0.pass,
         b0.err_count, b0.fail_seen,
         b0.fail_vec} !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset got %h exp 0",
        {b0.dut_in, b0.busy, b0.done, b0.pass,
         b0.err_count, b0.fail_seen, b0.fail_vec});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b0.busy, b0.done} !== 2'b00) begin
      errors++;
      $display("FAIL mid_idle got %b exp 00",
        {b0.busy, b0.done});
    end
    kick(0);
    wait_done(0, n);
    checks++;
    if (n != 16 || b0.pass !== 1'b1) begin
      errors++;
      $display("FAIL mid_rerun got %0d/%b exp 16/1",
        n, b0.pass);
    end
  endtask

  task automatic test_start_hold;
    int n;
    fault0 = 1'b1;
    b0.start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, n);
    checks++;
    if (n != L_FAULT0 ||
        b0.err_count !== 3'(E_FAULT0)) begin
      errors++;
      $display("FAIL hold_first got %0d/%0d exp %0d/%0d",
        n, b0.err_count, L_FAULT0, E_FAULT0);
    end
    @(posedge clk); #1;
    checks++;
    if ({b0.busy, b0.done} !== 2'b10) begin
      errors++;
      $display("FAIL hold_restart got %b exp 10",
        {b0.busy, b0.done});
    end
    repeat (2) @(posedge clk);
    #1;
    b0.start = 1'b0;
    wait_done(0, n);
    checks++;
    if (n != L_FAULT0 - 2) begin
      errors++;
      $display("FAIL hold_second got %0d exp %0d",
        n, L_FAULT0 - 2);
    end
    checks++;
    if (b0.err_count !== 3'(E_FAULT0) ||
        b0.fail_vec !== 2'd1 || b0.pass !== 1'b0) begin
      errors++;
      $display("FAIL hold_result got %0d/%0d/%b",
        b0.err_count, b0.fail_vec, b0.pass);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({b0.busy, b0.done} !== 2'b01) begin
      errors++;
      $display("FAIL hold_extra got %b exp 01",
        {b0.busy, b0.done});
    end
  endtask

  task automatic test_busy_pulse;
    int n;
    fault0 = 1'b0;
    kick(0);
    repeat (5) @(posedge clk);
    #1;
    b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    wait_done(0, n);
    checks++;
    if (n + 6 != 16) begin
      errors++;
      $display("FAIL pulse_latency got %0d exp 16",
        n + 6);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({b0.busy, b0.done, b0.pass} !== 3'b011) begin
      errors++;
      $display("FAIL pulse_extra got %b exp 011",
        {b0.busy, b0.done, b0.pass});
    end
  endtask

  task automatic test_settle0_x;
    int n;
    kick(1);
    wait_done(1, n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL x_latency got %0d exp 8", n);
    end
    checks++;
    if (b1.err_count !== 3'd1 ||
        b1.fail_vec !== 2'd3) begin
      errors++;
      $display("FAIL x_result got %0d/%0d exp 1/3",
        b1.err_count, b1.fail_vec);
    end
    checks++;
    if ({b1.pass, b1.fail_seen} !== 2'b01) begin
      errors++;
      $display("FAIL x_flags got %b exp 01",
        {b1.pass, b1.fail_seen});
    end
  endtask

  task automatic test_xor;
    int n;
    fault2 = 1'b1;
    kick(2);
    wait_done(2, n);
    checks++;
    if (n != L_FAULT2) begin
      errors++;
      $display("FAIL xor_f_latency got %0d exp %0d",
        n, L_FAULT2);
    end
    checks++;
    if (b2.err_count !== 4'd1 ||
        b2.fail_vec !== 3'd5 || b2.pass !== 1'b0) begin
      errors++;
      $display("FAIL xor_f_result got %0d/%0d/%b",
        b2.err_count, b2.fail_vec, b2.pass);
    end
    fault2 = 1'b0;
    kick(2);
    wait_done(2, n);
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL xor_latency got %0d exp 24", n);
    end
    checks++;
    if (b2.err_count !== 4'd0 ||
        b2.fail_vec !== 3'd0 || b2.pass !== 1'b1) begin
      errors++;
      $display("FAIL xor_result got %0d/%0d/%b",
        b2.err_count, b2.fail_vec, b2.pass);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    fault0   = 1'b0;
    fault2   = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_and_sweep();
    test_fault();
    test_reset_mid();
    test_start_hold();
    test_busy_pulse();
    test_settle0_x();
    test_xor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
